// File: rtl/sum_squares_mean.sv
// Streaming mean-square engine: squares each accepted sample, sums a block of
// 2**LOG2_LEN squares and emits the block mean as a one-cycle radicand pulse.
module sum_squares_mean #(
    parameter int WIDTH_SAMPLE = 8,
    parameter bit SIGNED       = 1'b1,
    parameter int LOG2_LEN     = 2,
    parameter int WIDTH_OUT    = 2*WIDTH_SAMPLE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH_SAMPLE-1:0] sample,
    output logic                    out_valid,
    output logic [WIDTH_OUT-1:0]    mean_sq,
    output logic [15:0]             blocks_done
);

    localparam int WIDTH_SQ  = 2*WIDTH_SAMPLE;
    localparam int WIDTH_ACC = WIDTH_SQ + LOG2_LEN;
    localparam int WIDTH_CNT = (LOG2_LEN == 0) ? 1 : LOG2_LEN;
    localparam logic [WIDTH_CNT-1:0] CNT_LAST =
        WIDTH_CNT'((64'd1 << LOG2_LEN) - 64'd1);

    logic                  accept;
    logic [WIDTH_SQ-1:0]   sample_ext;
    logic [WIDTH_SQ-1:0]   square_next;
    logic [WIDTH_SQ-1:0]   sq;
    logic                  sq_valid;
    logic [WIDTH_ACC-1:0]  acc;
    logic [WIDTH_ACC-1:0]  acc_sum;
    logic [WIDTH_CNT-1:0]  count;
    logic                  block_last;
    logic                  emit;

    assign in_ready = !clear;
    assign accept   = in_valid && !clear;

    // Squaring the 2W-bit extension modulo 2**(2W) gives the exact square,
    // since the true result always fits in 2W bits for either signedness.
    always_comb begin
        if (SIGNED)
            sample_ext = {{WIDTH_SAMPLE{sample[WIDTH_SAMPLE-1]}}, sample};
        else
            sample_ext = {{WIDTH_SAMPLE{1'b0}}, sample};
        square_next = sample_ext * sample_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq       <= '0;
            sq_valid <= 1'b0;
        end else begin
            sq_valid <= accept;
            if (accept)
                sq <= square_next;
        end
    end

    assign acc_sum    = acc + WIDTH_ACC'(sq);
    assign block_last = (count == CNT_LAST);
    assign emit       = sq_valid && block_last && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (sq_valid) begin
            if (block_last) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= acc_sum;
                count <= count + 1'b1;
            end
        end
    end

    // Truncating divide by the block length: drop the low LOG2_LEN bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            mean_sq     <= '0;
            blocks_done <= '0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                mean_sq     <= WIDTH_OUT'(acc_sum[WIDTH_ACC-1:LOG2_LEN]);
                blocks_done <= blocks_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sum_squares_mean.sv
// Scoreboard bench for sum_squares_mean: a signed LOG2_LEN=2 instance and an
// unsigned one, directed vectors with hand-computed block means.
module tb_sum_squares_mean;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  sample;
    logic        out_valid;
    logic [15:0] mean_sq;
    logic [15:0] blocks_done;

    logic        u_in_valid;
    logic        u_in_ready;
    logic [7:0]  u_sample;
    logic        u_out_valid;
    logic [15:0] u_mean_sq;
    logic [15:0] u_blocks_done;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    exp_t qu[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sum_squares_mean #(.WIDTH_SAMPLE(8), .SIGNED(1'b1), .LOG2_LEN(2)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .sample(sample), .out_valid(out_valid),
        .mean_sq(mean_sq), .blocks_done(blocks_done)
    );

    sum_squares_mean #(.WIDTH_SAMPLE(8), .SIGNED(1'b0), .LOG2_LEN(2)) dut_u (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(u_in_valid),
        .in_ready(u_in_ready), .sample(u_sample), .out_valid(u_out_valid),
        .mean_sq(u_mean_sq), .blocks_done(u_blocks_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle on the signed instance; if last, expect a pulse with val.
    task automatic send(input logic v, input logic [7:0] s, input logic clr,
                        input logic last, input logic [15:0] val);
        exp_t e;
        in_valid = v;
        sample   = s;
        clear    = clr;
        if (last) begin
            e.due = cyc + 2;
            e.val = val;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send_u(input logic v, input logic [7:0] s,
                          input logic last, input logic [15:0] val);
        exp_t e;
        u_in_valid = v;
        u_sample   = s;
        if (last) begin
            e.due = cyc + 2;
            e.val = val;
            qu.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid   = 1'b0;
        clear      = 1'b0;
        u_in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got mean_sq=%0d expected no pulse (cycle %0d)", mean_sq, cyc);
            end else begin
                e = q.pop_front();
                chk("mean_sq", 32'(mean_sq), 32'(e.val));
                chk("pulse_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (rst_n && u_out_valid) begin
            if (qu.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse_u: got mean_sq=%0d expected no pulse (cycle %0d)", u_mean_sq, cyc);
            end else begin
                e = qu.pop_front();
                chk("u_mean_sq", 32'(u_mean_sq), 32'(e.val));
                chk("u_pulse_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; sample = '0;
        u_in_valid = 1'b0; u_sample = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_mean_sq", 32'(mean_sq), 0);
        chk("rst_blocks_done", 32'(blocks_done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 1);
        chk("u_in_ready", 32'(u_in_ready), 1);

        // 3,-4,5,0 -> 50/4 = 12
        send(1, 8'd3, 0, 0, 0);
        send(1, 8'hFC, 0, 0, 0);
        send(1, 8'd5, 0, 0, 0);
        send(1, 8'd0, 0, 1, 16'd12);
        idle(3);
        chk("blocks_after_first", 32'(blocks_done), 1);

        // most negative sample
        for (int i = 0; i < 4; i++) send(1, 8'h80, 0, i == 3, 16'd16384);
        idle(3);
        chk("blocks_after_neg", 32'(blocks_done), 2);

        // 1..8 back to back -> 7 then 43, four cycles apart
        for (int i = 1; i <= 8; i++)
            send(1, 8'(i), 0, (i == 4) || (i == 8), (i == 4) ? 16'd7 : 16'd43);
        idle(3);
        chk("blocks_after_b2b", 32'(blocks_done), 4);
        chk("mean_sq_hold", 32'(mean_sq), 43);

        // gaps in in_valid
        for (int i = 0; i < 7; i++)
            send(i % 2 == 0, 8'd2, 0, i == 6, 16'd4);
        idle(3);
        chk("blocks_after_gaps", 32'(blocks_done), 5);

        // three 10s, clear while third square is in stage 1, then four 1s
        send(1, 8'd10, 0, 0, 0);
        send(1, 8'd10, 0, 0, 0);
        send(1, 8'd10, 0, 0, 0);
        send(0, 8'd0, 1, 0, 0);
        for (int i = 0; i < 4; i++) send(1, 8'd1, 0, i == 3, 16'd1);
        idle(3);
        chk("blocks_after_abort", 32'(blocks_done), 6);

        // clear while the completing square is in stage 1; offered sample dropped
        for (int i = 0; i < 4; i++) send(1, 8'd5, 0, 0, 0);
        in_valid = 1'b1; sample = 8'd7; clear = 1'b1;
        #1;
        chk("in_ready_clear", 32'(in_ready), 0);
        @(negedge clk);
        idle(4);
        chk("blocks_after_clear_last", 32'(blocks_done), 6);
        chk("mean_sq_kept_by_clear", 32'(mean_sq), 1);
        for (int i = 0; i < 4; i++) send(1, 8'd2, 0, i == 3, 16'd4);
        idle(3);
        chk("blocks_after_recover", 32'(blocks_done), 7);

        // unsigned instance, full-scale samples
        for (int i = 0; i < 4; i++) send_u(1, 8'd255, i == 3, 16'd65025);
        idle(3);
        chk("u_blocks_done", 32'(u_blocks_done), 1);

        // async reset mid-block
        send(1, 8'd9, 0, 0, 0);
        send(1, 8'd9, 0, 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_mean_sq", 32'(mean_sq), 0);
        chk("async_blocks_done", 32'(blocks_done), 0);
        chk("async_u_mean_sq", 32'(u_mean_sq), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(1, 8'd6, 0, i == 3, 16'd36);
        idle(4);
        chk("blocks_after_reset", 32'(blocks_done), 1);

        chk("scoreboard_drained", 32'(q.size()), 0);
        chk("scoreboard_u_drained", 32'(qu.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
